instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder: takes the team's 7-bit instruction code plus register, shift, immediate and target fields, and emits the 32-bit MIPS-I instruction word.
- Used by the program loader and by testbenches to build memory images from symbolic instructions.
- Valid/ready on both sides, a 2-entry output FIFO, range/legality checking, and accepted/error counters.

Parameters:
- FIFO_DEPTH, 2, output buffer entries. Only 2 is supported.
- CNT_W, 16, width of the accepted and error counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept
- instruction_code  in  7  team enumeration: 1 ADD, 2 ADDI, 3 ADDIU, 4 ADDU, 5 AND, 6 ANDI, 7 DIV, 8 DIVU, 9 MFHI, 10 MFLO, 11 MTHI, 12 MTLO, 13 MULT, 14 MULTU, 15 OR, 16 ORI, 17 SLL, 18 SLLV, 19 SLT, 20 SLTI, 21 SLTIU, 22 SLTU, 23 SRA, 24 SRAV, 25 SRL, 26 SRLV, 27 SUBU, 28 XOR, 29 XORI, 30 BEQ, 31 BGEZ, 32 BGEZAL, 33 BGTZ, 34 BLEZ, 35 BLTZ, 36 BLTZAL, 37 BNE, 38 J, 39 JAL, 40 JALR, 41 JR, 42 LB, 43 LBU, 44 LH, 45 LHU, 46 LUI, 47 LW, 48 LWL, 49 LWR, 50 SB, 51 SH, 52 SW
- destination_reg  in  5  rd for R-type, rt for I-type destinations
- reg_a_idx  in  5  rs or base register
- reg_b_idx  in  5  rt source (R-type, BEQ/BNE, stores)
- shift_amount  in  5  sa (SLL/SRL/SRA only)
- immediate  in  32  immediate value. For branches, a byte offset.
- memory  in  26  J/JAL target field
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts
- out_word  out  32  encoded instruction
- out_err  out  1  entry was illegal or out of range
- accepted_count  out  CNT_W  inputs accepted, saturating
- error_count  out  CNT_W  error entries produced, saturating

Behaviour:
- Reset (async, rst_n=0): FIFO empty; out_valid=0; out_word=0; out_err=0; both counters=0; in_ready=1 once rst_n deasserts.
- An input is accepted when in_valid and in_ready are both high. out_word and out_err are registered into the FIFO that edge; out_valid rises the next cycle. Latency is 1 cycle.
- in_ready = FIFO not full; it has no combinational dependence on out_ready.
- Simultaneous push and pop when full is not allowed (in_ready=0). When occupancy is 1, push and pop in the same cycle keep occupancy at 1.
- out_word and out_err show the FIFO head and are held stable while out_valid && !out_ready.
- Field packing, standard MIPS-I; unused fields are 0:
  - ALU R-type: rs=reg_a_idx, rt=reg_b_idx, rd=destination_reg, sa=0.
  - SLL/SRL/SRA: rs=0, sa=shift_amount.
  - MULT/MULTU/DIV/DIVU: rs, rt only.
  - MFHI/MFLO: rd only.
  - MTHI/MTLO/JR: rs only.
  - JALR: rs=reg_a_idx, rd=destination_reg.
  - I-type ALU and loads: rs=reg_a_idx, rt=destination_reg.
  - Stores: rs=base, rt=reg_b_idx.
  - LUI: rs=0.
  - BEQ/BNE: rs, rt. BGTZ/BLEZ: rt=0.
  - REGIMM (opcode 1) rt codes: BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001. destination_reg is ignored; the link to 31 is implicit.
  - J/JAL: field[25:0]=memory.
- Immediate checks:
  - ANDI/ORI/XORI/LUI: immediate[31:16] must be 0.
  - Other signed I-types: immediate must sign-fit in 16 bits.
  - Branches: immediate[1:0] must be 00 and the value must lie in [-131072, 131068]. Encoded field = immediate[17:2].
- Illegal code (0 or >52) or any failed check: out_word=0x00000000 (NOP) and out_err=1. The entry still occupies the FIFO and increments error_count.
- Counters: increment on accept (and on error entry for error_count); saturate at all-ones with no wrap.
- Reset asserted mid-operation clears all FIFO contents immediately; no partial word is emitted.

Test Plan:
- ADDU (4), rd=3, rs=1, rt=2 -> out_word=0x00221821, out_err=0, out_valid one cycle after accept.
- ADDIU (3), rt=2, rs=0, imm=5 -> 0x24020005. BEQ (30), rs=1, rt=2, imm=0xFFFFFFFC -> 0x1022FFFF.
- BGEZAL (32), rs=4, imm=8, destination_reg=7 -> 0x04910002. JAL (39), memory=0x0100000 -> 0x0C100000.
- ORI (16), imm=0x00010000 -> out_word=0, out_err=1, error_count=1. BNE, imm=6 -> err. Code 53 -> err.
- out_ready=0, push 3 back-to-back -> in_ready low after 2 accepts; the head word is held stable. Raise out_ready -> words drain in order and accepted_count=2 until the third is accepted.
- Pull rst_n low with 2 entries queued -> out_valid=0 and counters=0 immediately; the first post-reset input emerges 1 cycle after accept.

Source files
------------

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Field-input / word-output bus of the MIPS-I instruction
//                encoder. The master drives symbolic fields and consumes
//                encoded words; the slave is the encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  instruction_code;
    logic [4:0]  destination_reg;
    logic [4:0]  reg_a_idx;
    logic [4:0]  reg_b_idx;
    logic [4:0]  shift_amount;
    logic [31:0] immediate;
    logic [25:0] memory;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_err;

    modport master (
        output in_valid, instruction_code, destination_reg, reg_a_idx,
               reg_b_idx, shift_amount, immediate, memory, out_ready,
        input  in_ready, out_valid, out_word, out_err
    );

    modport slave (
        input  in_valid, instruction_code, destination_reg, reg_a_idx,
               reg_b_idx, shift_amount, immediate, memory, out_ready,
        output in_ready, out_valid, out_word, out_err
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Encodes the 7-bit team instruction code plus register,
//                shift, immediate and target fields into a 32-bit MIPS-I
//                word. Illegal codes or out-of-range immediates become a NOP
//                flagged with out_err. Results pass through a 2-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int FIFO_DEPTH = 2,   // only 2 is supported
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] accepted_count,
    output logic [CNT_W-1:0] error_count
);
    // Immediate check classes
    localparam logic [1:0] c_CHK_NONE = 2'd0;
    localparam logic [1:0] c_CHK_ZEXT = 2'd1;
    localparam logic [1:0] c_CHK_SEXT = 2'd2;
    localparam logic [1:0] c_CHK_BR   = 2'd3;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sa;
    logic [1:0]  w_chk;
    logic        w_jump, w_illegal, w_imm_ok, w_bad;
    logic [15:0] w_imm16;
    logic [31:0] w_word;
    logic        w_push, w_pop;

    logic [31:0]           r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_err_mem;
    logic                  r_wr_ptr, r_rd_ptr;
    logic [1:0]            r_count;
    logic [CNT_W-1:0]      r_acc_cnt, r_err_cnt;

    // Map the team instruction code onto MIPS-I opcode/funct and field routing
    always_comb begin
        w_op = 6'h00; w_fn = 6'h00; w_rs = 5'd0; w_rt = 5'd0; w_rd = 5'd0; w_sa = 5'd0;
        w_chk = c_CHK_NONE; w_jump = 1'b0; w_illegal = 1'b0;
        case (bus.instruction_code)
            7'd1 : begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h20; end // ADD
            7'd4 : begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h21; end // ADDU
            7'd5 : begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h24; end // AND
            7'd15: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h25; end // OR
            7'd18: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h04; end // SLLV
            7'd19: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h2A; end // SLT
            7'd22: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h2B; end // SLTU
            7'd24: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h07; end // SRAV
            7'd26: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h06; end // SRLV
            7'd27: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h23; end // SUBU
            7'd28: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_fn = 6'h26; end // XOR
            7'd17: begin w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_sa = bus.shift_amount; w_fn = 6'h00; end // SLL
            7'd25: begin w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_sa = bus.shift_amount; w_fn = 6'h02; end // SRL
            7'd23: begin w_rt = bus.reg_b_idx; w_rd = bus.destination_reg; w_sa = bus.shift_amount; w_fn = 6'h03; end // SRA
            7'd7 : begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_fn = 6'h1A; end // DIV
            7'd8 : begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_fn = 6'h1B; end // DIVU
            7'd13: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_fn = 6'h18; end // MULT
            7'd14: begin w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_fn = 6'h19; end // MULTU
            7'd9 : begin w_rd = bus.destination_reg; w_fn = 6'h10; end // MFHI
            7'd10: begin w_rd = bus.destination_reg; w_fn = 6'h12; end // MFLO
            7'd11: begin w_rs = bus.reg_a_idx; w_fn = 6'h11; end // MTHI
            7'd12: begin w_rs = bus.reg_a_idx; w_fn = 6'h13; end // MTLO
            7'd41: begin w_rs = bus.reg_a_idx; w_fn = 6'h08; end // JR
            7'd40: begin w_rs = bus.reg_a_idx; w_rd = bus.destination_reg; w_fn = 6'h09; end // JALR
            7'd2 : begin w_op = 6'h08; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // ADDI
            7'd3 : begin w_op = 6'h09; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // ADDIU
            7'd20: begin w_op = 6'h0A; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // SLTI
            7'd21: begin w_op = 6'h0B; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // SLTIU
            7'd6 : begin w_op = 6'h0C; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_ZEXT; end // ANDI
            7'd16: begin w_op = 6'h0D; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_ZEXT; end // ORI
            7'd29: begin w_op = 6'h0E; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_ZEXT; end // XORI
            7'd46: begin w_op = 6'h0F; w_rt = bus.destination_reg; w_chk = c_CHK_ZEXT; end // LUI
            7'd42: begin w_op = 6'h20; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // LB
            7'd43: begin w_op = 6'h24; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // LBU
            7'd44: begin w_op = 6'h21; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // LH
            7'd45: begin w_op = 6'h25; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // LHU
            7'd47: begin w_op = 6'h23; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // LW
            7'd48: begin w_op = 6'h22; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // LWL
            7'd49: begin w_op = 6'h26; w_rs = bus.reg_a_idx; w_rt = bus.destination_reg; w_chk = c_CHK_SEXT; end // LWR
            7'd50: begin w_op = 6'h28; w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_chk = c_CHK_SEXT; end // SB
            7'd51: begin w_op = 6'h29; w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_chk = c_CHK_SEXT; end // SH
            7'd52: begin w_op = 6'h2B; w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_chk = c_CHK_SEXT; end // SW
            7'd30: begin w_op = 6'h04; w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_chk = c_CHK_BR; end // BEQ
            7'd37: begin w_op = 6'h05; w_rs = bus.reg_a_idx; w_rt = bus.reg_b_idx; w_chk = c_CHK_BR; end // BNE
            7'd34: begin w_op = 6'h06; w_rs = bus.reg_a_idx; w_chk = c_CHK_BR; end // BLEZ
            7'd33: begin w_op = 6'h07; w_rs = bus.reg_a_idx; w_chk = c_CHK_BR; end // BGTZ
            7'd35: begin w_op = 6'h01; w_rs = bus.reg_a_idx; w_rt = 5'b00000; w_chk = c_CHK_BR; end // BLTZ
            7'd31: begin w_op = 6'h01; w_rs = bus.reg_a_idx; w_rt = 5'b00001; w_chk = c_CHK_BR; end // BGEZ
            7'd36: begin w_op = 6'h01; w_rs = bus.reg_a_idx; w_rt = 5'b10000; w_chk = c_CHK_BR; end // BLTZAL
            7'd32: begin w_op = 6'h01; w_rs = bus.reg_a_idx; w_rt = 5'b10001; w_chk = c_CHK_BR; end // BGEZAL
            7'd38: begin w_op = 6'h02; w_jump = 1'b1; end // J
            7'd39: begin w_op = 6'h03; w_jump = 1'b1; end // JAL
            default: w_illegal = 1'b1;
        endcase
    end

    // Range-check the immediate and assemble the final word (NOP on error)
    always_comb begin
        w_imm_ok = 1'b1;
        w_imm16  = bus.immediate[15:0];
        case (w_chk)
            c_CHK_ZEXT: w_imm_ok = (bus.immediate[31:16] == 16'h0000);
            c_CHK_SEXT: w_imm_ok = (bus.immediate[31:15] == 17'h00000) || (bus.immediate[31:15] == 17'h1FFFF);
            c_CHK_BR: begin
                // Byte offset must be word aligned and fit an 18-bit signed value
                w_imm_ok = (bus.immediate[1:0] == 2'b00) &&
                           ((bus.immediate[31:17] == 15'h0000) || (bus.immediate[31:17] == 15'h7FFF));
                w_imm16  = bus.immediate[17:2];
            end
            default: w_imm_ok = 1'b1;
        endcase
        w_bad = w_illegal || !w_imm_ok;
        if (w_bad)
            w_word = 32'h0000_0000;
        else if (w_jump)
            w_word = {w_op, bus.memory};
        else if (w_op == 6'h00)
            w_word = {w_op, w_rs, w_rt, w_rd, w_sa, w_fn};
        else
            w_word = {w_op, w_rs, w_rt, w_imm16};
    end

    assign bus.in_ready  = (r_count != 2'(FIFO_DEPTH));
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_word  = bus.out_valid ? r_mem[r_rd_ptr] : 32'h0000_0000;
    assign bus.out_err   = bus.out_valid ? r_err_mem[r_rd_ptr] : 1'b0;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 32'h0000_0000;
            r_err_mem <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr]     <= w_word;
                r_err_mem[r_wr_ptr] <= w_bad;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            if (w_push && !w_pop)
                r_count <= r_count + 2'd1;
            else if (!w_push && w_pop)
                r_count <= r_count - 2'd1;
        end
    end

    // Saturating accepted / error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push && (r_acc_cnt != '1))
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            if (w_push && w_bad && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign accepted_count = r_acc_cnt;
    assign error_count    = r_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Directed self-checking bench for instr_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    localparam int c_CNT_W = 16;

    logic clk;
    logic rst_n;
    logic [c_CNT_W-1:0] accepted_count;
    logic [c_CNT_W-1:0] error_count;

    int n_checks;
    int n_errors;
    int exp_acc;
    int exp_err;

    instr_encoder_if bus ();

    instr_encoder #(.FIFO_DEPTH(2), .CNT_W(c_CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .accepted_count (accepted_count),
        .error_count    (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] code, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] sa, input logic [31:0] imm,
                         input logic [25:0] mem);
        bus.instruction_code = code;
        bus.destination_reg  = d;
        bus.reg_a_idx        = a;
        bus.reg_b_idx        = b;
        bus.shift_amount     = sa;
        bus.immediate        = imm;
        bus.memory           = mem;
    endtask

    // Push one entry with out_ready high; check it appears one cycle later and then drains
    task automatic encode(input string tag, input logic [6:0] code, input logic [4:0] d,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] sa,
                          input logic [31:0] imm, input logic [25:0] mem,
                          input logic [31:0] exp_word, input logic exp_e);
        drive(code, d, a, b, sa, imm, mem);
        bus.in_valid = 1'b1;
        check_eq({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_acc++;
        if (exp_e) exp_err++;
        check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_eq({tag, "_word"}, bus.out_word, exp_word);
        check_eq({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, exp_e});
        check_eq({tag, "_acc"}, {16'd0, accepted_count}, exp_acc);
        check_eq({tag, "_errcnt"}, {16'd0, error_count}, exp_err);
        @(posedge clk); #1;
        check_eq({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0; exp_acc = 0; exp_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0);
        #12;
        check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_word", bus.out_word, 32'd0);
        check_eq("rst_err", {31'd0, bus.out_err}, 32'd0);
        check_eq("rst_acc", {16'd0, accepted_count}, 32'd0);
        check_eq("rst_errcnt", {16'd0, error_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("idle_valid", {31'd0, bus.out_valid}, 32'd0);

        //      tag        code   rd     rs     rt     sa     imm            memory        expected      err
        encode("addu",    7'd4,  5'd3,  5'd1,  5'd2,  5'd0,  32'd0,         26'd0,        32'h00221821, 1'b0);
        encode("addiu",   7'd3,  5'd2,  5'd0,  5'd0,  5'd0,  32'd5,         26'd0,        32'h24020005, 1'b0);
        encode("beq",     7'd30, 5'd0,  5'd1,  5'd2,  5'd0,  32'hFFFFFFFC,  26'd0,        32'h1022FFFF, 1'b0);
        encode("bgezal",  7'd32, 5'd7,  5'd4,  5'd0,  5'd0,  32'd8,         26'd0,        32'h04910002, 1'b0);
        encode("jal",     7'd39, 5'd0,  5'd0,  5'd0,  5'd0,  32'd0,         26'h0100000,  32'h0C100000, 1'b0);
        encode("sll",     7'd17, 5'd4,  5'd9,  5'd5,  5'd3,  32'd0,         26'd0,        32'h000520C0, 1'b0);
        encode("sw",      7'd52, 5'd0,  5'd29, 5'd31, 5'd0,  32'hFFFFFFF8,  26'd0,        32'hAFBFFFF8, 1'b0);
        encode("addi_lo", 7'd2,  5'd1,  5'd0,  5'd0,  5'd0,  32'hFFFF8000,  26'd0,        32'h20018000, 1'b0);
        encode("beq_max", 7'd30, 5'd0,  5'd0,  5'd0,  5'd0,  32'd131068,    26'd0,        32'h10007FFF, 1'b0);
        encode("bltz_min",7'd35, 5'd9,  5'd3,  5'd0,  5'd0,  32'hFFFE0000,  26'd0,        32'h04608000, 1'b0);
        encode("ori_big", 7'd16, 5'd1,  5'd1,  5'd0,  5'd0,  32'h00010000,  26'd0,        32'h00000000, 1'b1);
        encode("bne_mis", 7'd37, 5'd0,  5'd1,  5'd2,  5'd0,  32'd6,         26'd0,        32'h00000000, 1'b1);
        encode("code53",  7'd53, 5'd1,  5'd1,  5'd1,  5'd0,  32'd0,         26'd0,        32'h00000000, 1'b1);
        encode("beq_ovr", 7'd30, 5'd0,  5'd0,  5'd0,  5'd0,  32'd131072,    26'd0,        32'h00000000, 1'b1);
        encode("addi_ovr",7'd2,  5'd1,  5'd0,  5'd0,  5'd0,  32'h00008000,  26'd0,        32'h00000000, 1'b1);
        encode("code0",   7'd0,  5'd0,  5'd0,  5'd0,  5'd0,  32'd0,         26'd0,        32'h00000000, 1'b1);

        // Backpressure: fill the FIFO, hold the head, then drain in order
        bus.out_ready = 1'b0;
        drive(7'd4, 5'd3, 5'd1, 5'd2, 5'd0, 32'd0, 26'd0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
        drive(7'd17, 5'd4, 5'd0, 5'd5, 5'd3, 32'd0, 26'd0);
        @(posedge clk); #1;
        check_eq("bp_full", {31'd0, bus.in_ready}, 32'd0);
        check_eq("bp_head", bus.out_word, 32'h00221821);
        drive(7'd39, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'h0100000);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_hold", bus.out_word, 32'h00221821);
        check_eq("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
        check_eq("bp_acc2", {16'd0, accepted_count}, exp_acc + 2);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_second", bus.out_word, 32'h000520C0);
        check_eq("bp_acc_wait", {16'd0, accepted_count}, exp_acc + 2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("bp_third", bus.out_word, 32'h0C100000);
        check_eq("bp_acc3", {16'd0, accepted_count}, exp_acc + 3);
        exp_acc += 3;
        @(posedge clk); #1;
        check_eq("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset with two entries queued
        bus.out_ready = 1'b0;
        drive(7'd3, 5'd2, 5'd0, 5'd0, 5'd0, 32'd5, 26'd0);
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq("ar_queued", {31'd0, bus.in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_acc = 0;
        exp_err = 0;
        check_eq("ar_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("ar_word", bus.out_word, 32'd0);
        check_eq("ar_acc", {16'd0, accepted_count}, 32'd0);
        check_eq("ar_errcnt", {16'd0, error_count}, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        encode("post_rst", 7'd3, 5'd2, 5'd0, 5'd0, 5'd0, 32'd5, 26'd0, 32'h24020005, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
